ahb_mbox_reader: RTL and testbench

- AHB-Lite master that consumes messages posted into one channel of the AHB mailbox slave.
- On the mailbox interrupt it reads that channel's control word. If the channel is full, it reads `size` payload words from mailbox RAM and streams them out on a valid/ready interface. It then writes the control word back with intr=0 and full=0.
- Sits directly downstream of the mailbox, on the same AHB segment, in front of the local consumer (e.g. a coprocessor command FIFO).

---
 rtl/ahb_mbox_reader_pkg.sv | 37 +++
 rtl/ahb_mbox_reader.sv | 231 +++++++++++++++++++++++
 tb/tb_ahb_mbox_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mbox_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_mbox_reader_pkg                                                  |
// | AHB-Lite encodings and mailbox control-word layout shared by the     |
// | mailbox slave and its reader.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahb_mbox_reader_pkg;

  localparam logic [1:0]  HTRANS_IDLE     = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0]  HSIZE_WORD      = 3'b010;
  localparam logic [2:0]  HBURST_SINGLE   = 3'b000;
  localparam logic [3:0]  HPROT_DATA_PRIV = 4'b0011;
  localparam logic [1:0]  HRESP_OKAY      = 2'b00;
  localparam logic [1:0]  HRESP_ERROR     = 2'b01;
  localparam logic [31:0] MBOX_RAM_OFFSET = 32'h0000_8000;

  typedef struct packed {
    logic        intr;
    logic        full;
    logic [6:0]  rsvd;
    logic [14:0] size;
    logic [7:0]  id;
  } mbox_ctrl_t;

  // Control word as written back once a message has been consumed.
  function automatic mbox_ctrl_t mbox_ctrl_release(input mbox_ctrl_t c);
    mbox_ctrl_t r;
    r      = c;
    r.intr = 1'b0;
    r.full = 1'b0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mbox_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_mbox_reader                                                      |
// | AHB-Lite master draining one mailbox channel onto a valid/ready      |
// | stream, then releasing the channel's control word.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_mbox_reader
  import ahb_mbox_reader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] MBOX_BASE  = 32'h0,
  parameter int          CHANNEL    = 0,
  parameter int          MAX_WORDS  = 8192
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  mailbox_intr,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic [1:0]            hresp,
  input  logic [DATA_WIDTH-1:0] hrdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [7:0]            m_id,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    RC_A = 4'd1,
    RC_D = 4'd2,
    RD_A = 4'd3,
    RD_D = 4'd4,
    PUSH = 4'd5,
    WC_A = 4'd6,
    WC_D = 4'd7,
    FAIL = 4'd8
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_ctrl_addr = ADDR_WIDTH'(MBOX_BASE) +
      ((CHANNEL != 0) ? ADDR_WIDTH'(4) : ADDR_WIDTH'(0));
  localparam logic [ADDR_WIDTH-1:0] c_ram_base =
      ADDR_WIDTH'(MBOX_BASE) + ADDR_WIDTH'(MBOX_RAM_OFFSET);
  localparam logic [14:0] c_max_words = 15'(MAX_WORDS);

  state_t                r_state, w_state;
  mbox_ctrl_t            r_ctrl, w_ctrl;
  logic [12:0]           r_idx, w_idx;
  logic [ADDR_WIDTH-1:0] r_haddr, w_haddr;
  logic                  r_hwrite, w_hwrite;
  logic [DATA_WIDTH-1:0] r_hwdata, w_hwdata;
  logic                  r_m_valid, w_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data, w_m_data;
  logic [7:0]            r_m_id, w_m_id;
  logic                  r_m_last, w_m_last;
  logic                  r_err, w_err;
  logic                  w_set_err;
  logic                  w_go_wc;
  logic                  w_is_last;
  logic                  w_err_resp;
  mbox_ctrl_t            w_hr_ctrl;

  function automatic logic [ADDR_WIDTH-1:0] ram_addr(input logic [12:0] idx);
    return c_ram_base + ADDR_WIDTH'({idx, 2'b00});
  endfunction

  assign w_hr_ctrl  = mbox_ctrl_t'(hrdata[31:0]);
  assign w_err_resp = (hresp == HRESP_ERROR);
  assign w_is_last  = ({2'b00, r_idx} == (r_ctrl.size - 15'd1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= IDLE;
      r_ctrl    <= '0;
      r_idx     <= '0;
      r_haddr   <= '0;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_id    <= '0;
      r_m_last  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ctrl    <= w_ctrl;
      r_idx     <= w_idx;
      r_haddr   <= w_haddr;
      r_hwrite  <= w_hwrite;
      r_hwdata  <= w_hwdata;
      r_m_valid <= w_m_valid;
      r_m_data  <= w_m_data;
      r_m_id    <= w_m_id;
      r_m_last  <= w_m_last;
      r_err     <= w_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_ctrl    = r_ctrl;
    w_idx     = r_idx;
    w_haddr   = r_haddr;
    w_hwrite  = r_hwrite;
    w_hwdata  = r_hwdata;
    w_m_valid = r_m_valid;
    w_m_data  = r_m_data;
    w_m_id    = r_m_id;
    w_m_last  = r_m_last;
    w_set_err = 1'b0;
    w_go_wc   = 1'b0;

    case (r_state)
      IDLE: begin
        if (mailbox_intr && !r_err) begin
          w_state  = RC_A;
          w_haddr  = c_ctrl_addr;
          w_hwrite = 1'b0;
        end
      end
      RC_A: w_state = RC_D;
      RC_D: begin
        if (hready) begin
          w_ctrl = w_hr_ctrl;
          if (w_err_resp) begin
            w_state = FAIL;
          end else if (!w_hr_ctrl.intr || !w_hr_ctrl.full) begin
            // Nothing posted on this channel; the interrupt belongs elsewhere.
            w_state = IDLE;
          end else if (w_hr_ctrl.size > c_max_words) begin
            w_set_err = 1'b1;
            w_go_wc   = 1'b1;
          end else if (w_hr_ctrl.size == 15'd0) begin
            w_go_wc = 1'b1;
          end else begin
            w_idx   = '0;
            w_state = RD_A;
            w_haddr = ram_addr(13'd0);
          end
        end
      end
      RD_A: w_state = RD_D;
      RD_D: begin
        if (hready) begin
          if (w_err_resp) begin
            w_state = FAIL;
          end else begin
            w_m_valid = 1'b1;
            w_m_data  = hrdata;
            w_m_id    = r_ctrl.id;
            w_m_last  = w_is_last;
            w_state   = PUSH;
          end
        end
      end
      PUSH: begin
        if (m_ready) begin
          w_m_valid = 1'b0;
          w_m_last  = 1'b0;
          if (r_m_last) begin
            w_go_wc = 1'b1;
          end else begin
            w_idx   = r_idx + 13'd1;
            w_state = RD_A;
            w_haddr = ram_addr(r_idx + 13'd1);
          end
        end
      end
      WC_A: w_state = WC_D;
      WC_D: begin
        if (hready) begin
          if (w_err_resp) begin
            w_set_err = 1'b1;
          end
          w_hwrite = 1'b0;
          w_state  = IDLE;
        end
      end
      FAIL: begin
        w_set_err = 1'b1;
        w_state   = IDLE;
      end
      default: w_state = IDLE;
    endcase

    if (w_go_wc) begin
      w_state  = WC_A;
      w_haddr  = c_ctrl_addr;
      w_hwrite = 1'b1;
      w_hwdata = DATA_WIDTH'(mbox_ctrl_release(w_ctrl));
    end

    // A coincident error event outranks a clear request.
    if (w_set_err) begin
      w_err = 1'b1;
    end else if (err_clr) begin
      w_err = 1'b0;
    end else begin
      w_err = r_err;
    end
  end

  assign htrans  = (r_state == RC_A || r_state == RD_A || r_state == WC_A) ?
                   HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr   = r_haddr;
  assign hwrite  = r_hwrite;
  assign hwdata  = r_hwdata;
  assign hsize   = HSIZE_WORD;
  assign hburst  = HBURST_SINGLE;
  assign hprot   = HPROT_DATA_PRIV;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_id    = r_m_id;
  assign m_last  = r_m_last;
  assign busy    = (r_state != IDLE);
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mbox_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_mbox_reader                                                   |
// | Scoreboard bench with an AHB mailbox slave model for ahb_mbox_reader.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ahb_mbox_reader;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        mailbox_intr;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        m_valid;
  logic [31:0] m_data;
  logic [7:0]  m_id;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        err;
  logic        err_clr;

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } xfer_t;
  typedef struct { logic [31:0] data; logic [7:0] id; logic last; } beat_t;

  xfer_t       exp_xfer[$];
  beat_t       exp_beat[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] ctrl_word = 32'h0;
  logic [31:0] ram [0:15];
  logic        intr_force = 1'b0;
  int          ws = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;

  assign mailbox_intr = ctrl_word[31] | intr_force;

  always #5 hclk = ~hclk;

  ahb_mbox_reader dut (
    .hclk(hclk), .hresetn(hresetn), .mailbox_intr(mailbox_intr),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hresp(hresp), .hrdata(hrdata), .m_valid(m_valid), .m_data(m_data),
    .m_id(m_id), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .err(err), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'h8000) >> 2;
    if (a == 32'h0) return ctrl_word;
    if (a >= 32'h8000 && a < 32'h8040) return ram[off[3:0]];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic push_x(input logic wr, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.wdata = d;
    exp_xfer.push_back(x);
  endtask

  task automatic push_b(input logic [31:0] d, input logic [7:0] id, input logic last);
    beat_t b;
    b.data = d; b.id = id; b.last = last;
    exp_beat.push_back(b);
  endtask

  task automatic push_msg305();
    push_x(1'b0, 32'h0, 32'h0);
    push_x(1'b0, 32'h8000, 32'h0);
    push_x(1'b0, 32'h8004, 32'h0);
    push_x(1'b0, 32'h8008, 32'h0);
    push_x(1'b1, 32'h0, 32'h0000_0305);
    push_b(32'h11, 8'h05, 1'b0);
    push_b(32'h22, 8'h05, 1'b0);
    push_b(32'h33, 8'h05, 1'b1);
  endtask

  task automatic wait_level(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge hclk);
      if (busy === lvl) break;
    end
    check(name, 32'(busy), 32'(lvl));
  endtask

  task automatic run_done(input string name, input logic exp_err);
    wait_level(1'b1, 50, {name, " busy rise"});
    wait_level(1'b0, 400, {name, " busy fall"});
    repeat (5) @(negedge hclk);
    check({name, " ahb xfers left"}, 32'(exp_xfer.size()), 32'd0);
    check({name, " beats left"}, 32'(exp_beat.size()), 32'd0);
    check({name, " busy idle"}, 32'(busy), 32'd0);
    check({name, " err"}, 32'(err), 32'(exp_err));
  endtask

  // AHB mailbox slave: control word at 0x0, payload RAM at 0x8000.
  initial begin : slave
    xfer_t       x;
    logic [31:0] a;
    logic [31:0] wd;
    logic        w;
    logic        is_err;
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = 32'h0;
    forever begin
      @(negedge hclk);
      if (hresetn && htrans == 2'b10) begin
        a = haddr;
        w = hwrite;
        if (exp_xfer.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected AHB transfer: got %s addr %h expected none",
                   w ? "write" : "read", a);
          x.wr = w; x.addr = a; x.wdata = 32'h0;
        end else begin
          x = exp_xfer.pop_front();
          check("ahb haddr", a, x.addr);
          check("ahb hwrite", 32'(w), 32'(x.wr));
        end
        if (a >= 32'h8000) check("m_valid low at RAM read", 32'(m_valid), 32'd0);
        is_err = err_en && !w && (a == err_addr);
        @(posedge hclk); #1;
        for (int i = 0; i < ws; i++) begin
          hready = 1'b0;
          @(negedge hclk);
          check("wait haddr", haddr, x.addr);
          check("wait hwrite", 32'(hwrite), 32'(x.wr));
          check("wait htrans", 32'(htrans), 32'd0);
          if (x.wr) check("wait hwdata", hwdata, x.wdata);
          @(posedge hclk); #1;
        end
        if (is_err) begin
          hready = 1'b0;
          hresp  = 2'b01;
          @(posedge hclk); #1;
        end
        hready = 1'b1;
        hresp  = is_err ? 2'b01 : 2'b00;
        hrdata = w ? 32'h0 : rd_word(a);
        @(negedge hclk);
        wd = hwdata;
        if (w) check("ahb hwdata", wd, x.wdata);
        @(posedge hclk); #1;
        if (w && a == 32'h0) ctrl_word = wd;
        hresp  = 2'b00;
        hrdata = 32'h0;
      end
    end
  end

  initial begin : stream_mon
    beat_t b;
    forever begin
      @(negedge hclk);
      if (hresetn && m_valid) begin
        if (exp_beat.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected stream beat: got data %h expected none", m_data);
        end else begin
          b = exp_beat[0];
          check("m_data", m_data, b.data);
          check("m_id", 32'(m_id), 32'(b.id));
          check("m_last", 32'(m_last), 32'(b.last));
          if (m_ready) b = exp_beat.pop_front();
        end
      end
    end
  end

  initial begin : guard
    #300000;
    n_fail++;
    $display("FAIL global timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    m_ready = 1'b1;
    err_clr = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    ram[0] = 32'h11;
    ram[1] = 32'h22;
    ram[2] = 32'h33;

    #1;
    check("rst htrans", 32'(htrans), 32'd0);
    check("rst hwrite", 32'(hwrite), 32'd0);
    check("rst haddr", haddr, 32'd0);
    check("rst hwdata", hwdata, 32'd0);
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_last", 32'(m_last), 32'd0);
    check("rst m_data", m_data, 32'd0);
    check("rst m_id", 32'(m_id), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("hsize", 32'(hsize), 32'd2);
    check("hburst", 32'(hburst), 32'd0);
    check("hprot", 32'(hprot), 32'd3);
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;

    // Basic three-word message.
    push_msg305();
    ctrl_word = 32'hC000_0305;
    run_done("t1", 1'b0);

    // Same message, consumer stalls after the first beat.
    push_msg305();
    ctrl_word = 32'hC000_0305;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge hclk);
          if (m_valid && m_ready) break;
        end
        @(posedge hclk); #1;
        m_ready = 1'b0;
        repeat (10) @(posedge hclk);
        #1 m_ready = 1'b1;
      end
      run_done("t2", 1'b0);
    join

    // Empty message: release only.
    push_x(1'b0, 32'h0, 32'h0);
    push_x(1'b1, 32'h0, 32'h0000_0007);
    ctrl_word = 32'hC000_0007;
    run_done("t3", 1'b0);

    // Spurious interrupt: one control read, nothing else.
    push_x(1'b0, 32'h0, 32'h0);
    ctrl_word = 32'h0;
    @(posedge hclk); #1 intr_force = 1'b1;
    @(posedge hclk); #1 intr_force = 1'b0;
    run_done("t4", 1'b0);

    // Bus error on the second RAM read.
    push_x(1'b0, 32'h0, 32'h0);
    push_x(1'b0, 32'h8000, 32'h0);
    push_x(1'b0, 32'h8004, 32'h0);
    push_b(32'h11, 8'h05, 1'b0);
    err_en   = 1'b1;
    err_addr = 32'h8004;
    ctrl_word = 32'hC000_0305;
    run_done("t5", 1'b1);
    repeat (20) @(negedge hclk);
    check("t5 no restart while err", 32'(busy), 32'd0);
    check("t5 ctrl untouched", ctrl_word, 32'hC000_0305);
    err_en = 1'b0;
    push_msg305();
    @(posedge hclk); #1 err_clr = 1'b1;
    @(posedge hclk); #1 err_clr = 1'b0;
    check("t5 err cleared", 32'(err), 32'd0);
    run_done("t5 restart", 1'b0);

    // Oversized message with wait states on every data phase.
    ws = 6;
    push_x(1'b0, 32'h0, 32'h0);
    push_x(1'b1, 32'h0, 32'h0020_01AB);
    ctrl_word = 32'hC020_01AB;
    run_done("t6", 1'b1);
    ws = 0;
    check("t6 ctrl released", ctrl_word, 32'h0020_01AB);
    @(posedge hclk); #1 err_clr = 1'b1;
    @(posedge hclk); #1 err_clr = 1'b0;
    check("t6 err cleared", 32'(err), 32'd0);
    repeat (5) @(negedge hclk);
    check("final busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
